wb_ctrl_pipe: RTL and testbench

WB_CTRL_PIPE -- requirements
Module: wb_ctrl_pipe

---
 rtl/wb_ctrl_pipe.sv | 145 ++++++++++++++
 tb/tb_wb_ctrl_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl_pipe.sv
// M->W control pipeline: STAGES register stages, W-side writeback controls decoded from the last stage.
// Define COND_WRITE_EN to let movz/bgezal write conditionally on the carried compare result.
module wb_ctrl_pipe #(
   parameter int STAGES = 1,
   parameter int RA_W   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instr_m,
   input  logic            cmprst_m,
   input  logic            valid_m,
   input  logic            stall,
   input  logic            flush,
   output logic [1:0]      mem2reg,
   output logic            reg_we,
   output logic [RA_W-1:0] reg_addr,
   output logic            exl_clr,
   output logic            valid_w,
   output logic [31:0]     instr_w
);

`ifdef COND_WRITE_EN
   localparam bit COND_EN = 1'b1;
`else
   localparam bit COND_EN = 1'b0;
`endif

   localparam logic [31:0] ERET = 32'h4200_0018;

   logic [31:0] r_instr  [STAGES] = '{default: '0};
   logic        r_cmprst [STAGES] = '{default: 1'b0};
   logic        r_valid  [STAGES] = '{default: 1'b0};

   // Flush kills stage 1 even while stalled; later stages still obey stall.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < STAGES; k++) begin
            r_instr[k]  <= '0;
            r_cmprst[k] <= 1'b0;
            r_valid[k]  <= 1'b0;
         end
      end else begin
         if (flush) begin
            r_instr[0]  <= '0;
            r_cmprst[0] <= 1'b0;
            r_valid[0]  <= 1'b0;
         end else if (!stall) begin
            r_instr[0]  <= instr_m;
            r_cmprst[0] <= cmprst_m;
            r_valid[0]  <= valid_m;
         end
         if (!stall) begin
            for (int k = 1; k < STAGES; k++) begin
               r_instr[k]  <= r_instr[k-1];
               r_cmprst[k] <= r_cmprst[k-1];
               r_valid[k]  <= r_valid[k-1];
            end
         end
      end
   end

   logic [31:0]     w_instr;
   logic            w_cmprst;
   logic            w_valid;
   logic [5:0]      w_op;
   logic [5:0]      w_fn;
   logic [4:0]      w_rs;
   logic [4:0]      w_rt;
   logic [4:0]      w_rd;
   logic            w_wset;
   logic            w_cond;
   logic [1:0]      w_src;
   logic [RA_W-1:0] w_dest;

   assign w_instr  = r_instr[STAGES-1];
   assign w_cmprst = r_cmprst[STAGES-1];
   assign w_valid  = r_valid[STAGES-1];
   assign w_op     = w_instr[31:26];
   assign w_rs     = w_instr[25:21];
   assign w_rt     = w_instr[20:16];
   assign w_rd     = w_instr[15:11];
   assign w_fn     = w_instr[5:0];

   // w_cond marks movz/bgezal: they write only when the carried compare result allows it.
   always_comb begin
      w_wset = 1'b0;
      w_cond = 1'b0;
      w_src  = 2'd0;
      w_dest = '0;
      case (w_op)
         6'h00: begin
            case (w_fn)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h10, 6'h12,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                  w_wset = 1'b1;
                  w_dest = RA_W'(w_rd);
               end
               default: ;
            endcase
            if (w_fn == 6'h0A) begin
               w_wset = 1'b0;
               w_cond = 1'b1;
            end
            if (w_fn == 6'h09) w_src = 2'd2;
         end
         6'h01: begin
            if (w_rt == 5'h11 && COND_EN) begin
               w_cond = 1'b1;
               w_dest = RA_W'(31);
               w_src  = 2'd2;
            end
         end
         6'h03: begin
            w_wset = 1'b1;
            w_dest = RA_W'(31);
            w_src  = 2'd2;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            w_wset = 1'b1;
            w_dest = RA_W'(w_rt);
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            w_wset = 1'b1;
            w_dest = RA_W'(w_rt);
            w_src  = 2'd1;
         end
         6'h10: begin
            if (w_rs == 5'd0) begin
               w_wset = 1'b1;
               w_dest = RA_W'(w_rt);
               w_src  = 2'd3;
            end
         end
         default: ;
      endcase
   end

   assign mem2reg  = w_valid ? w_src : 2'd0;
   assign reg_addr = w_valid ? w_dest : '0;
   assign reg_we   = w_valid && (w_wset || (w_cond && COND_EN && w_cmprst)) && (w_dest != '0);
   assign exl_clr  = w_valid && (w_instr == ERET);
   assign valid_w  = w_valid;
   assign instr_w  = w_instr;

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Bench for wb_ctrl_pipe: three depths (1,2,3) share one input stream and are checked each cycle
// against a history-queue reference model, plus directed scenario checks.
module tb_wb_ctrl_pipe;

`ifdef COND_WRITE_EN
   localparam bit COND_EN = 1'b1;
`else
   localparam bit COND_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic        cmp;
      logic        vld;
   } ent_t;

   logic        clk;
   logic        reset;
   logic [31:0] instr_m;
   logic        cmprst_m;
   logic        valid_m;
   logic        stall;
   logic        flush;

   logic [1:0]  m2r [3];
   logic        we  [3];
   logic [4:0]  addr[3];
   logic        exl [3];
   logic        vw  [3];
   logic [31:0] iw  [3];

   int n_chk  = 0;
   int n_pass = 0;

   ent_t hist[$];

   wb_ctrl_pipe #(.STAGES(1), .RA_W(5)) u_s1 (
      .clk(clk), .reset(reset), .instr_m(instr_m), .cmprst_m(cmprst_m), .valid_m(valid_m),
      .stall(stall), .flush(flush), .mem2reg(m2r[0]), .reg_we(we[0]), .reg_addr(addr[0]),
      .exl_clr(exl[0]), .valid_w(vw[0]), .instr_w(iw[0]));
   wb_ctrl_pipe #(.STAGES(2), .RA_W(5)) u_s2 (
      .clk(clk), .reset(reset), .instr_m(instr_m), .cmprst_m(cmprst_m), .valid_m(valid_m),
      .stall(stall), .flush(flush), .mem2reg(m2r[1]), .reg_we(we[1]), .reg_addr(addr[1]),
      .exl_clr(exl[1]), .valid_w(vw[1]), .instr_w(iw[1]));
   wb_ctrl_pipe #(.STAGES(3), .RA_W(5)) u_s3 (
      .clk(clk), .reset(reset), .instr_m(instr_m), .cmprst_m(cmprst_m), .valid_m(valid_m),
      .stall(stall), .flush(flush), .mem2reg(m2r[2]), .reg_we(we[2]), .reg_addr(addr[2]),
      .exl_clr(exl[2]), .valid_w(vw[2]), .instr_w(iw[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode of one instruction straight from the opcode/funct rules.
   function automatic logic [41:0] exp_o(input ent_t e);
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd, dst;
      logic       wr, cnd, wen;
      logic [1:0] src;
      op  = e.instr[31:26];
      rs  = e.instr[25:21];
      rt  = e.instr[20:16];
      rd  = e.instr[15:11];
      fn  = e.instr[5:0];
      wr  = 1'b0;
      cnd = 1'b0;
      src = 2'd0;
      dst = rt;
      if (op == 6'h00 && fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h0A,
                                    6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                    6'h26, 6'h27, 6'h2A, 6'h2B}) begin
         wr  = 1'b1;
         dst = rd;
      end
      if (op inside {6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                     6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) wr = 1'b1;
      if (op == 6'h10 && rs == 5'd0) begin
         wr  = 1'b1;
         src = 2'd3;
      end
      if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) src = 2'd1;
      if (op == 6'h03) begin
         dst = 5'd31;
         src = 2'd2;
      end
      if (op == 6'h00 && fn == 6'h09) src = 2'd2;
      if (op == 6'h00 && fn == 6'h0A) begin
         wr  = 1'b0;
         cnd = 1'b1;
      end
      if (op == 6'h01 && rt == 5'h11 && COND_EN) begin
         cnd = 1'b1;
         dst = 5'd31;
         src = 2'd2;
      end
      if (!(wr || cnd)) dst = 5'd0;
      wen = (wr || (cnd && COND_EN && e.cmp)) && (dst != 5'd0);
      if (!e.vld) return {10'd0, e.instr};
      return {src, wen, dst, (e.instr == 32'h4200_0018), 1'b1, e.instr};
   endfunction

   function automatic logic [41:0] obs(input int s);
      return {m2r[s], we[s], addr[s], exl[s], vw[s], iw[s]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_chk++;
      assert (o === e) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, o, e);
   endtask

   // One clock: drive inputs, advance the history model at the edge, then check all depths.
   task automatic step(input logic [31:0] ins, input logic c, input logic v,
                       input logic st, input logic fl, input logic rs_n);
      ent_t ne;
      instr_m  = ins;
      cmprst_m = c;
      valid_m  = v;
      stall    = st;
      flush    = fl;
      reset    = rs_n;
      @(posedge clk);
      ne = fl ? '0 : ent_t'{ins, c, v};
      if (!rs_n) begin
         hist.delete();
         repeat (4) hist.push_back('0);
      end else if (!st) begin
         hist.push_front(ne);
         void'(hist.pop_back());
      end else if (fl) begin
         hist[0] = '0;
      end
      #1;
      for (int s = 0; s < 3; s++)
         chk($sformatf("model_s%0d", s + 1), 64'(obs(s)), 64'(exp_o(hist[s])));
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [5:0] fns [8] = '{6'h00, 6'h09, 6'h0A, 6'h21, 6'h2B, 6'h08, 6'h0B, 6'h26};
      logic [5:0] ops [10] = '{6'h03, 6'h08, 6'h0D, 6'h0F, 6'h20, 6'h23, 6'h25, 6'h22, 6'h04, 6'h2B};
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0: return r;
         1, 2: return {6'h00, r[25:6], fns[$urandom_range(0, 7)]};
         3: return {ops[$urandom_range(0, 9)], r[25:0]};
         4: return 32'h4200_0018;
         5: return {6'h01, r[25:21], ($urandom_range(0, 1) == 1) ? 5'h11 : r[20:16], r[15:0]};
         default: return {6'h10, ($urandom_range(0, 1) == 1) ? 5'd0 : r[25:21], r[20:0]};
      endcase
   endfunction

   localparam logic [31:0] ADDU3  = 32'h0022_1821;
   localparam logic [31:0] LW8    = 32'h8C08_0000;
   localparam logic [31:0] JAL    = 32'h0C00_0000;
   localparam logic [31:0] ADDIU4 = 32'h2404_0001;
   localparam logic [31:0] ADDIU6 = 32'h2406_0002;
   localparam logic [31:0] ORI7   = 32'h3407_0007;
   localparam logic [31:0] ORI0   = 32'h3400_0005;
   localparam logic [31:0] ERET   = 32'h4200_0018;
   localparam logic [31:0] MOVZ5  = 32'h0022_280A;
   localparam logic [31:0] BGEZAL = 32'h0471_0000;

   initial begin
      instr_m = '0; cmprst_m = 1'b0; valid_m = 1'b0; stall = 1'b0; flush = 1'b0; reset = 1'b0;
      repeat (4) hist.push_back('0);

      step('0, 0, 0, 0, 0, 0);
      step('0, 0, 0, 0, 0, 0);
      chk("reset_outputs_zero", 64'(obs(2)), 64'd0);

      step(ADDU3, 0, 1, 0, 0, 1);
      chk("addu_s1", {m2r[0], we[0], addr[0], vw[0]}, {2'd0, 1'b1, 5'd3, 1'b1});

      step(LW8, 0, 1, 0, 0, 1);
      step(JAL, 0, 1, 0, 0, 1);
      step('0, 0, 0, 0, 0, 1);
      chk("lw_at_s3", {m2r[2], addr[2]}, {2'd1, 5'd8});
      step('0, 0, 0, 0, 0, 1);
      chk("jal_at_s3", {m2r[2], addr[2]}, {2'd2, 5'd31});

      step(ADDIU4, 0, 1, 0, 0, 1);
      step(ADDIU6, 0, 1, 0, 0, 1);
      chk("s2_before_stall", addr[1], 5'd4);
      step(ORI7, 0, 1, 1, 0, 1);
      chk("s2_stall1_frozen", addr[1], 5'd4);
      step(ORI7, 0, 1, 1, 0, 1);
      chk("s2_stall2_frozen", addr[1], 5'd4);
      step('0, 0, 0, 0, 0, 1);
      chk("s2_after_stall", addr[1], 5'd6);
      step(ORI7, 0, 1, 1, 1, 1);
      step('0, 0, 0, 0, 0, 1);
      chk("s2_flush_bubble", {vw[1], iw[1]}, 33'd0);

      step(ERET, 0, 1, 0, 0, 1);
      chk("eret", {exl[0], we[0]}, 2'b10);
      step('0, 0, 1, 0, 0, 1);
      chk("nop_valid", {exl[0], we[0], vw[0]}, 3'b001);
      step(ORI0, 0, 1, 0, 0, 1);
      chk("ori_r0", we[0], 1'b0);

      step(MOVZ5, 1, 1, 0, 0, 1);
      chk("movz_cmp1_we", we[0], COND_EN);
      if (COND_EN) chk("movz_cmp1_addr", addr[0], 5'd5);
      step(MOVZ5, 0, 1, 0, 0, 1);
      chk("movz_cmp0_we", we[0], 1'b0);
      step(BGEZAL, 1, 1, 0, 0, 1);
      chk("bgezal_cmp1", {m2r[0], we[0], addr[0]}, COND_EN ? {2'd2, 1'b1, 5'd31} : 8'd0);

      step(ADDIU4, 0, 1, 0, 0, 1);
      step(ADDIU6, 0, 1, 0, 0, 1);
      step(ADDU3, 0, 1, 0, 0, 1);
      step(LW8, 0, 1, 1, 0, 0);
      for (int s = 0; s < 3; s++) chk($sformatf("reset_in_stall_s%0d", s + 1), 64'(obs(s)), 64'd0);

      for (int i = 0; i < 500; i++)
         step(rnd_instr(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) != 0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
